// File: rtl/noc_buf_pkg.sv
// Shared types and width helpers for the NoC router input buffer.
// Types here are sized for the default configuration; modules derive their own widths from parameters.
package noc_buf_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_DEPTH      = 8;
  localparam int DEF_NUM_VC     = 2;

  // Index width that never collapses to zero bits for a single-entry range.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_VC_W  = idx_w(DEF_NUM_VC);
  localparam int DEF_PTR_W = idx_w(DEF_DEPTH);
  localparam int DEF_CNT_W = $clog2(DEF_DEPTH + 1);

  typedef logic [DEF_DATA_WIDTH-1:0] flit_t;
  typedef logic [DEF_VC_W-1:0]       vc_idx_t;

endpackage

// File: rtl/vc_fifo_ctrl.sv
// Pointer and occupancy bookkeeping for one virtual channel; storage lives in the parent.
module vc_fifo_ctrl #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_acc,
  input  logic             rd_acc,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  // Explicit wrap so non-power-of-two depths skip the unused pointer codes.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= next_ptr(wr_ptr);
      if (rd_acc) rd_ptr <= next_ptr(rd_ptr);
      if (wr_acc && !rd_acc)      count <= count + CNT_W'(1);
      else if (rd_acc && !wr_acc) count <= count - CNT_W'(1);
    end
  end

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/vc_input_buffer.sv
// Router input buffer: NUM_VC FIFOs over one shared flit array, with credit return and sticky error flags.
module vc_input_buffer
  import noc_buf_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int NUM_VC     = DEF_NUM_VC,
  localparam int VC_W      = idx_w(NUM_VC),
  localparam int PTR_W     = idx_w(DEPTH),
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en_i,
  input  logic [VC_W-1:0]         wr_vc_i,
  input  logic [DATA_WIDTH-1:0]   wr_data_i,
  input  logic                    rd_en_i,
  input  logic [VC_W-1:0]         rd_vc_i,
  output logic [DATA_WIDTH-1:0]   rd_data_o,
  output logic                    rd_valid_o,
  output logic                    credit_o,
  output logic [VC_W-1:0]         credit_vc_o,
  output logic [NUM_VC-1:0]       empty_o,
  output logic [NUM_VC-1:0]       full_o,
  output logic [NUM_VC*CNT_W-1:0] count_o,
  output logic                    overflow_o,
  output logic                    underflow_o
);

  // Handshake: no backpressure. wr_en_i/rd_en_i are requests accepted or rejected in the
  // same cycle; a rejected request is dropped and raises overflow_o/underflow_o. An accepted
  // read yields rd_valid_o=1 with rd_data_o and a credit_o pulse exactly one cycle later.

  logic [DATA_WIDTH-1:0] mem [NUM_VC][DEPTH];
  logic [PTR_W-1:0]      rd_ptr_v [NUM_VC];
  logic [PTR_W-1:0]      wr_ptr_v [NUM_VC];
  logic [CNT_W-1:0]      cnt_v    [NUM_VC];
  logic                  wr_vc_ok, rd_vc_ok, wr_acc, rd_acc;

  assign wr_vc_ok = (int'(wr_vc_i) < NUM_VC);
  assign rd_vc_ok = (int'(rd_vc_i) < NUM_VC);

  // A same-VC read frees a slot this cycle, so a full VC may still accept the write.
  assign rd_acc = rd_en_i && rd_vc_ok && !empty_o[rd_vc_i];
  assign wr_acc = wr_en_i && wr_vc_ok &&
                  (!full_o[wr_vc_i] || (rd_acc && (rd_vc_i == wr_vc_i)));

  for (genvar g = 0; g < NUM_VC; g++) begin : g_vc
    vc_fifo_ctrl #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W),
      .CNT_W (CNT_W)
    ) u_ctrl (
      .clk    (clk),
      .reset  (reset),
      .wr_acc (wr_acc && (int'(wr_vc_i) == g)),
      .rd_acc (rd_acc && (int'(rd_vc_i) == g)),
      .rd_ptr (rd_ptr_v[g]),
      .wr_ptr (wr_ptr_v[g]),
      .count  (cnt_v[g]),
      .empty  (empty_o[g]),
      .full   (full_o[g])
    );
    assign count_o[g*CNT_W +: CNT_W] = cnt_v[g];
  end

  // Storage is deliberately not reset; stale contents are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (wr_acc && !reset) mem[wr_vc_i][wr_ptr_v[wr_vc_i]] <= wr_data_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_o   <= '0;
      rd_valid_o  <= 1'b0;
      credit_o    <= 1'b0;
      credit_vc_o <= '0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      rd_valid_o <= rd_acc;
      credit_o   <= rd_acc;
      if (rd_acc) begin
        rd_data_o   <= mem[rd_vc_i][rd_ptr_v[rd_vc_i]];
        credit_vc_o <= rd_vc_i;
      end
      if (wr_en_i && !wr_acc) overflow_o  <= 1'b1;
      if (rd_en_i && !rd_acc) underflow_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vc_input_buffer.sv
// Bench: two buffers (DEPTH 8 and DEPTH 5) share stimulus; a queue model predicts every output.
module tb_vc_input_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en_i, rd_en_i;
  logic        wr_vc_i, rd_vc_i;
  logic [15:0] wr_data_i;

  logic [15:0] rd_data_a, rd_data_b;
  logic        rd_valid_a, rd_valid_b, credit_a, credit_b, cvc_a, cvc_b;
  logic [1:0]  empty_a, empty_b, full_a, full_b;
  logic [7:0]  count_a;
  logic [5:0]  count_b;
  logic        ovf_a, ovf_b, unf_a, unf_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vc_input_buffer #(.DATA_WIDTH(16), .DEPTH(8), .NUM_VC(2)) u_dut_a (
    .clk(clk), .reset(reset), .wr_en_i(wr_en_i), .wr_vc_i(wr_vc_i), .wr_data_i(wr_data_i),
    .rd_en_i(rd_en_i), .rd_vc_i(rd_vc_i), .rd_data_o(rd_data_a), .rd_valid_o(rd_valid_a),
    .credit_o(credit_a), .credit_vc_o(cvc_a), .empty_o(empty_a), .full_o(full_a),
    .count_o(count_a), .overflow_o(ovf_a), .underflow_o(unf_a));

  vc_input_buffer #(.DATA_WIDTH(16), .DEPTH(5), .NUM_VC(2)) u_dut_b (
    .clk(clk), .reset(reset), .wr_en_i(wr_en_i), .wr_vc_i(wr_vc_i), .wr_data_i(wr_data_i),
    .rd_en_i(rd_en_i), .rd_vc_i(rd_vc_i), .rd_data_o(rd_data_b), .rd_valid_o(rd_valid_b),
    .credit_o(credit_b), .credit_vc_o(cvc_b), .empty_o(empty_b), .full_o(full_b),
    .count_o(count_b), .overflow_o(ovf_b), .underflow_o(unf_b));

  // ---------------- reference model ----------------
  logic [15:0] exp_q [2][2][$];
  int          dep [2] = '{8, 5};
  logic [15:0] m_data [2];
  logic        m_valid [2], m_credit [2], m_cvc [2], m_ovf [2], m_unf [2];
  logic        live = 1'b0;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        exp_q[i][0].delete();
        exp_q[i][1].delete();
        m_data[i] = '0; m_valid[i] = 0; m_credit[i] = 0; m_cvc[i] = 0;
        m_ovf[i] = 0; m_unf[i] = 0;
      end else begin
        bit rd_ok, wr_ok;
        rd_ok = rd_en_i && (exp_q[i][rd_vc_i].size() > 0);
        wr_ok = wr_en_i && ((exp_q[i][wr_vc_i].size() < dep[i]) || (rd_ok && rd_vc_i == wr_vc_i));
        m_valid[i]  = rd_ok;
        m_credit[i] = rd_ok;
        if (rd_ok) begin
          m_data[i] = exp_q[i][rd_vc_i].pop_front();
          m_cvc[i]  = rd_vc_i;
        end
        if (rd_en_i && !rd_ok) m_unf[i] = 1'b1;
        if (wr_ok) exp_q[i][wr_vc_i].push_back(wr_data_i);
        else if (wr_en_i) m_ovf[i] = 1'b1;
      end
    end
    if (reset) live = 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic chk_inst(input int i, input logic rv, input logic [15:0] rd, input logic cr,
                          input logic cvc, input logic [1:0] emp, input logic [1:0] ful,
                          input logic [3:0] c0, input logic [3:0] c1, input logic ov, input logic un);
    string p;
    p = (i == 0) ? "d8" : "d5";
    chk({p, ".rd_valid"}, 32'(rv), 32'(m_valid[i]));
    chk({p, ".rd_data"}, 32'(rd), 32'(m_data[i]));
    chk({p, ".credit"}, 32'(cr), 32'(m_credit[i]));
    if (m_credit[i]) chk({p, ".credit_vc"}, 32'(cvc), 32'(m_cvc[i]));
    for (int v = 0; v < 2; v++) begin
      int n;
      n = exp_q[i][v].size();
      chk($sformatf("%s.empty[%0d]", p, v), 32'(emp[v]), 32'(n == 0));
      chk($sformatf("%s.full[%0d]", p, v), 32'(ful[v]), 32'(n == dep[i]));
      chk($sformatf("%s.count[%0d]", p, v), 32'((v == 0) ? c0 : c1), 32'(n));
    end
    chk({p, ".overflow"}, 32'(ov), 32'(m_ovf[i]));
    chk({p, ".underflow"}, 32'(un), 32'(m_unf[i]));
  endtask

  // Compare process: every output checked against the model each cycle once reset has been seen.
  always @(negedge clk) begin
    if (live) begin
      chk_inst(0, rd_valid_a, rd_data_a, credit_a, cvc_a, empty_a, full_a,
               count_a[3:0], count_a[7:4], ovf_a, unf_a);
      chk_inst(1, rd_valid_b, rd_data_b, credit_b, cvc_b, empty_b, full_b,
               {1'b0, count_b[2:0]}, {1'b0, count_b[5:3]}, ovf_b, unf_b);
    end
  end

  // ---------------- driver ----------------
  task automatic cyc(input logic r, input logic we, input logic wv, input logic [15:0] wd,
                     input logic re, input logic rv);
    reset = r; wr_en_i = we; wr_vc_i = wv; wr_data_i = wd; rd_en_i = re; rd_vc_i = rv;
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b1; wr_en_i = 0; wr_vc_i = 0; wr_data_i = 0; rd_en_i = 0; rd_vc_i = 0;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("reset.empty", 32'(empty_a), 32'h3);
    chk("reset.count", 32'(count_a), 32'h0);
    chk("reset.rd_valid", 32'(rd_valid_a), 32'h0);

    // Fill VC0, then one write too many.
    for (int k = 0; k < 9; k++) cyc(0, 1, 0, 16'hA001 + 16'(k), 0, 0);
    chk("fill.full0", 32'(full_a[0]), 32'h1);
    chk("fill.count0", 32'(count_a[3:0]), 32'h8);
    chk("fill.empty1", 32'(empty_a[1]), 32'h1);
    chk("fill.overflow", 32'(ovf_a), 32'h1);

    for (int k = 0; k < 8; k++) begin
      cyc(0, 0, 0, 0, 1, 0);
      chk("drain.data", 32'(rd_data_a), 32'hA001 + 32'(k));
      chk("drain.valid", 32'(rd_valid_a), 32'h1);
      chk("drain.credit", 32'(credit_a), 32'h1);
      chk("drain.credit_vc", 32'(cvc_a), 32'h0);
    end
    cyc(0, 0, 0, 0, 0, 0);
    chk("drain.empty0", 32'(empty_a[0]), 32'h1);

    // Interleaved traffic on VC1 walks the pointers through several wraps.
    cyc(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 12; k++) begin
      cyc(0, 1, 1, 16'hC000 + 16'(k), k > 0, 1);
      if (k > 0) chk("wrap.data", 32'(rd_data_a), 32'hC000 + 32'(k - 1));
      if (k > 0) chk("wrap.data_d5", 32'(rd_data_b), 32'hC000 + 32'(k - 1));
    end
    cyc(0, 0, 0, 0, 1, 1);
    chk("wrap.last", 32'(rd_data_a), 32'hC00B);
    chk("wrap.errors", 32'({ovf_a, unf_a, ovf_b, unf_b}), 32'h0);

    // Full VC accepts a write alongside a same-VC read.
    cyc(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) cyc(0, 1, 0, 16'hD000 + 16'(k), 0, 0);
    cyc(0, 1, 0, 16'hBEEF, 1, 0);
    chk("rdwr.count0", 32'(count_a[3:0]), 32'h8);
    chk("rdwr.data", 32'(rd_data_a), 32'hD000);
    chk("rdwr.overflow", 32'(ovf_a), 32'h0);
    for (int k = 0; k < 8; k++) cyc(0, 0, 0, 0, 1, 0);
    chk("rdwr.beef_last", 32'(rd_data_a), 32'hBEEF);

    // Write and read to an empty VC in one cycle: no bypass.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 16'h1234, 1, 1);
    chk("bypass.underflow", 32'(unf_a), 32'h1);
    chk("bypass.no_valid", 32'(rd_valid_a), 32'h0);
    cyc(0, 0, 0, 0, 1, 1);
    chk("bypass.data", 32'(rd_data_a), 32'h1234);
    chk("bypass.valid", 32'(rd_valid_a), 32'h1);

    // Reset with a read pending discards everything.
    cyc(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) cyc(0, 1, 0, 16'hE000 + 16'(k), 0, 0);
    cyc(1, 0, 0, 0, 1, 0);
    chk("rst.valid", 32'(rd_valid_a), 32'h0);
    chk("rst.credit", 32'(credit_a), 32'h0);
    chk("rst.count", 32'(count_a), 32'h0);
    chk("rst.empty", 32'(empty_a), 32'h3);
    chk("rst.flags", 32'({ovf_a, unf_a}), 32'h0);

    // Random traffic, with rare resets to clear the sticky flags.
    for (int k = 0; k < 3000; k++) begin
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)),
          16'($urandom), $urandom_range(0, 9) < 5, 1'($urandom_range(0, 1)));
    end
    cyc(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vc_input_buffer.md
Name: vc_input_buffer

Overview:
Next-generation NoC router input buffer with NUM_VC independent virtual-channel FIFOs sharing one flit storage array. Each VC owns DEPTH slots and keeps its own read pointer, write pointer and occupancy count. It adds full detection, correct wrap-around for any DEPTH, registered read data, credit return to the upstream router, and sticky overflow/underflow error flags. It sits between the link input and the router's VC allocator/switch.

Parameters:
DATA_WIDTH, 16, flit width in bits
DEPTH, 8, slots per VC; any value >= 2, not only powers of two
NUM_VC, 2, number of virtual channels; >= 1
VC_W, $clog2(NUM_VC) (min 1), VC index width (derived)
PTR_W, $clog2(DEPTH), slot pointer width (derived)
CNT_W, $clog2(DEPTH+1), occupancy count width (derived)

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
wr_en_i  in  1  write request
wr_vc_i  in  VC_W  target VC of write
wr_data_i  in  DATA_WIDTH  flit to store
rd_en_i  in  1  read request
rd_vc_i  in  VC_W  source VC of read
rd_data_o  out  DATA_WIDTH  flit read (registered)
rd_valid_o  out  1  rd_data_o valid this cycle
credit_o  out  1  one-cycle credit return pulse to upstream
credit_vc_o  out  VC_W  VC the credit belongs to
empty_o  out  NUM_VC  per-VC empty flag
full_o  out  NUM_VC  per-VC full flag
count_o  out  NUM_VC*CNT_W  per-VC occupancy, VC0 in LSBs
overflow_o  out  1  sticky: write rejected
underflow_o  out  1  sticky: read rejected

Behaviour:
- Reset (while reset=1 at a clk edge): all pointers/counts 0; empty_o all 1; full_o all 0; count_o 0; rd_valid_o, credit_o, overflow_o, underflow_o 0; rd_data_o 0; credit_vc_o 0. Storage contents are not reset. Reset asserted mid-operation discards all stored flits; a rd_en_i/wr_en_i in the same cycle as reset is ignored.
- empty_o/full_o/count_o are combinational from registered count: empty = (count==0), full = (count==DEPTH).
- Read accept: rd_en_i && !empty[rd_vc_i]. Accepted read: the slot at rd_ptr is presented on rd_data_o the next cycle with rd_valid_o=1; rd_ptr advances; credit_o=1 and credit_vc_o=rd_vc_i on that same next cycle. Latency 1 cycle. rd_data_o holds its last value when rd_valid_o=0.
- Write accept: wr_en_i && (!full[wr_vc_i] || (read accepted on same VC this cycle)). Accepted write stores at wr_ptr and advances wr_ptr; data readable from the following cycle (no same-cycle bypass).
- Pointer wrap: pointer at DEPTH-1 advances to 0.
- Count: +1 on accepted write only, -1 on accepted read only, unchanged when both occur on the same VC. Different VCs update independently.
- Read of empty VC: ignored, no rd_valid_o, no credit, underflow_o set. Write to full VC without same-VC read: flit dropped, state unchanged, overflow_o set. Sticky flags clear only on reset.
- Simultaneous write to VC a and read from VC b (a!=b) both proceed; the storage array is one write port and one read port.
- Out-of-range VC index (>= NUM_VC) is treated as rejected for that operation and sets the matching error flag.

Decomposition:
- Package noc_buf_pkg: flit_t (logic [DATA_WIDTH-1:0]), vc_idx_t, and the derived-width helper constants.
- Sub-module vc_fifo_ctrl, instantiated NUM_VC times: holds rd_ptr, wr_ptr and count for one VC; inputs wr_acc/rd_acc; outputs pointers, empty, full and count. The top level holds the shared storage array, accept logic, output registers and error flags.

Test Plan:
- Reset, then write 0xA001..0xA008 to VC0 (DEPTH=8) -> full_o[0]=1, count VC0=8, empty_o[1]=1; 9th write 0xA009 -> dropped, overflow_o=1, count stays 8.
- Read VC0 eight times back-to-back -> rd_valid_o each following cycle, data 0xA001..0xA008 in order, credit_o pulses with credit_vc_o=0 each time; empty_o[0]=1 afterwards.
- With DEPTH=5, write/read 12 flits to VC1 interleaved -> pointers wrap 4->0 with correct order; no errors.
- VC0 full; same cycle rd_en VC0 and wr_en VC0 0xBEEF -> both accepted, count stays 8, 0xBEEF read out last.
- Empty VC1; same cycle wr_en VC1 0x1234 and rd_en VC1 -> write accepted, read rejected, underflow_o=1, next-cycle read returns 0x1234.
- Fill VC0 with 3 flits, assert reset for one cycle while rd_en_i=1 -> no rd_valid_o or credit, count 0, empty_o all 1, sticky flags 0.
